button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Front end for the button peripheral. Takes raw asynchronous push-buttons from the board pins.
//  Per channel it does three things:
//   - 2-FF synchronizer into clk;
//   - debounce by a consecutive-sample FSM;
//   - drives a clean level bus, one-cycle press/release pulses and sticky press flags.
//  btn_stable feeds the button peripheral's button[4:0] input; btn_event/evt_clr give the bridge
//  a read-and-clear view.
// PARAMETERS
//  N_BTN            5        number of button channels
//  DEBOUNCE_CYCLES  1000000  consecutive agreeing samples needed to accept a new level (>=1); 10 ms at 100 MHz
//  ACTIVE_LOW       0        1: raw input inverted before sync (pressed = pin low)
//  CNT_W            derived  localparam = $clog2(DEBOUNCE_CYCLES+1); per-channel counter width
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous, active-high reset
//  btn_raw      in   N_BTN  raw pin levels, asynchronous to clk
//  evt_clr      in   N_BTN  one-cycle clear mask for btn_event (from bridge on read)
//  btn_stable   out  N_BTN  debounced level, 1 = pressed
//  btn_press    out  N_BTN  1-cycle pulse on accepted 0->1 of btn_stable
//  btn_release  out  N_BTN  1-cycle pulse on accepted 1->0 of btn_stable
//  btn_event    out  N_BTN  sticky: set by btn_press, cleared by evt_clr
// BEHAVIOUR
//  Reset (async assert, sync release). All of the following go to 0:
//   - sync flops, counters, btn_stable, btn_press, btn_release, btn_event;
//   - FSM state -> STABLE.
//  Sync: s[i] = 2nd flop of a 2-FF chain on (btn_raw[i] ^ ACTIVE_LOW). No other logic sees btn_raw.
//  Per-channel FSM, 2 states, x = btn_stable[i]:
//   STABLE, s==x: hold; cnt=0.
//   STABLE, s!=x: if DEBOUNCE_CYCLES==1, accept now. Else -> CHECK, cnt=1.
//   CHECK, s==x (bounce): -> STABLE, cnt=0. No output change; the check restarts from zero next time.
//   CHECK, s!=x: if cnt==DEBOUNCE_CYCLES-1, accept. Else cnt=cnt+1.
//   accept: btn_stable[i] <= s, -> STABLE, cnt=0, on the same edge:
//    - btn_press[i] <= s;
//    - btn_release[i] <= ~s.
//  Counter: never exceeds DEBOUNCE_CYCLES-1, so no wrap.
//  Latency: raw held steady after a change -> btn_stable changes on the (DEBOUNCE_CYCLES+2)th rising clk
//   edge (2 sync + DEBOUNCE_CYCLES samples). Pulses coincide with that edge and last exactly 1 cycle.
//  Pulses: press/release are registered, default 0 every cycle. They never assert together on one channel.
//  btn_event[i] next value:
//   - btn_press[i] asserting this edge -> 1;
//   - else if evt_clr[i] -> 0;
//   - else hold.
//   Simultaneous set and clear: set wins, so no press is lost.
//  Channels are fully independent; any mix may accept on the same edge.
//  Reset mid-CHECK aborts the check and drops all state to 0, with no pulse.
//   A button held through reset is detected as a fresh press DEBOUNCE_CYCLES+2 edges after release of rst.
//  All outputs are registered; no combinational path from input to output.
// TESTING (bench uses DEBOUNCE_CYCLES=4, N_BTN=5, ACTIVE_LOW=0)
//  1. Reset release, btn_raw=0 for 20 cycles -> all outputs 0 throughout.
//  2. Press: btn_raw[0] 0->1 and held.
//     -> btn_stable[0]=1 and btn_press[0]=1 on the 6th edge; pulse 1 cycle; btn_event[0]=1 sticky.
//  3. Bounce: btn_raw[2] toggles 1,0,1,0 every 2 cycles then settles at 1.
//     -> no output change during bounce; btn_stable[2] rises on the 6th edge after the final 0->1.
//  4. Release of 5'b00001 -> btn_release[0] 1-cycle pulse on the 6th edge; btn_event[0] unaffected.
//  5. evt_clr=5'b00001 in the same cycle btn_press[0] pulses -> btn_event[0] stays 1.
//     evt_clr the next cycle -> btn_event[0]=0.
//  6. rst pulsed at sample 2 of 4 while btn_raw=5'b11111 held.
//     -> outputs 0 during reset; after release all five btn_press pulse together on the 6th edge.

Source files
------------

// File: rtl/button_debounce.sv
// Button front end: per-channel 2-FF synchronizer, consecutive-sample debounce FSM,
// registered press/release pulses and sticky press flags with a read-and-clear port.

module button_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic evt_clr,
    output logic btn_stable,
    output logic btn_press,
    output logic btn_release,
    output logic btn_event
);
    typedef enum logic {STABLE = 1'b0, CHECK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             stable_nxt, press_nxt, release_nxt, event_nxt, accept;

    // Polarity is folded in before the chain so everything downstream sees 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], btn_raw ^ ACTIVE_LOW};
    end

    assign s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STABLE;
            cnt         <= '0;
            btn_stable  <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_event   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_stable  <= stable_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
            btn_event   <= event_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stable_nxt  = btn_stable;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        accept      = 1'b0;
        case (state)
            STABLE: begin
                cnt_nxt = '0;
                if (s != btn_stable) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = CHECK;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            CHECK: begin
                // A single agreeing sample is a bounce: the run restarts from zero.
                if (s == btn_stable) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
        if (accept) begin
            stable_nxt  = s;
            state_nxt   = STABLE;
            cnt_nxt     = '0;
            press_nxt   = s;
            release_nxt = ~s;
        end
        // Set beats clear so a press landing on the bridge's read is never lost.
        event_nxt = press_nxt ? 1'b1 : (evt_clr ? 1'b0 : btn_event);
    end
endmodule

module button_debounce #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] evt_clr,
    output logic [N_BTN-1:0] btn_stable,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_event
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .evt_clr    (evt_clr[i]),
            .btn_stable (btn_stable[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_event  (btn_event[i])
        );
    end
endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4: a vector table for
// press/release/clear plus hand sequences for bounce and reset-mid-check.

module tb_button_debounce;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw, evt_clr;
    logic [N-1:0] btn_stable, btn_press, btn_release, btn_event;

    int errors = 0;
    int checks = 0;

    button_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .evt_clr    (evt_clr),
        .btn_stable (btn_stable),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_event  (btn_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] raw, clr;
        logic [N-1:0] stable, press, rel, evt;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] es, ep, er, ee);
        checks++;
        if ({btn_stable, btn_press, btn_release, btn_event} !== {es, ep, er, ee}) begin
            errors++;
            $display("FAIL %s: got stable=%b press=%b release=%b event=%b, want stable=%b press=%b release=%b event=%b",
                     name, btn_stable, btn_press, btn_release, btn_event, es, ep, er, ee);
        end
    endtask

    function automatic vec_t v(input logic [N-1:0] raw, clr, st, pr, rl, ev);
        vec_t r;
        r.raw = raw; r.clr = clr; r.stable = st; r.press = pr; r.rel = rl; r.evt = ev;
        return r;
    endfunction

    initial begin
        // Press ch0: accepted on 6th edge, pulse one cycle, event sticky.
        for (int k = 1; k <= 5; k++) tbl.push_back(v(5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0));
        tbl.push_back(v(5'b00001, 5'b0, 5'b00001, 5'b00001, 5'b0, 5'b00001));
        tbl.push_back(v(5'b00001, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b00001));
        tbl.push_back(v(5'b00001, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b00001));
        // Release ch0: release pulse on 6th edge, event untouched.
        for (int k = 1; k <= 5; k++) tbl.push_back(v(5'b0, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b00001));
        tbl.push_back(v(5'b0, 5'b0, 5'b0, 5'b0, 5'b00001, 5'b00001));
        tbl.push_back(v(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00001));
        // Plain clear.
        tbl.push_back(v(5'b0, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0));
        tbl.push_back(v(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0));
        // Re-press with clear on the accepting edge: set wins; clear next cycle takes.
        for (int k = 1; k <= 5; k++) tbl.push_back(v(5'b00001, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0));
        tbl.push_back(v(5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b0, 5'b00001));
        tbl.push_back(v(5'b00001, 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0));
        tbl.push_back(v(5'b00001, 5'b0, 5'b00001, 5'b0, 5'b0, 5'b0));

        rst = 1'b1; btn_raw = '0; evt_clr = '0;
        #1 chk("reset_state", 5'b0, 5'b0, 5'b0, 5'b0);
        tick(); tick();
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("idle_%0d", k), 5'b0, 5'b0, 5'b0, 5'b0);
        end

        foreach (tbl[k]) begin
            btn_raw = tbl[k].raw;
            evt_clr = tbl[k].clr;
            tick();
            chk($sformatf("vec_%0d", k), tbl[k].stable, tbl[k].press, tbl[k].rel, tbl[k].evt);
        end
        evt_clr = '0;

        // Bounce on ch2 (ch0 still held): 1,0,1,0 every 2 cycles, then settles high.
        for (int seg = 0; seg < 4; seg++) begin
            for (int k = 0; k < 2; k++) begin
                btn_raw = (seg % 2 == 0) ? 5'b00101 : 5'b00001;
                tick();
                chk($sformatf("bounce_%0d_%0d", seg, k), 5'b00001, 5'b0, 5'b0, 5'b0);
            end
        end
        btn_raw = 5'b00101;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("settle_%0d", k), 5'b00001, 5'b0, 5'b0, 5'b0);
        end
        tick();
        chk("settle_accept", 5'b00101, 5'b00100, 5'b0, 5'b00100);
        tick();
        chk("settle_after", 5'b00101, 5'b0, 5'b0, 5'b00100);

        // All held; reset lands mid-check (sample 2 of 4 on the newly pressed channels).
        btn_raw = 5'b11111;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        #1 chk("rst_async", 5'b0, 5'b0, 5'b0, 5'b0);
        tick();
        chk("rst_hold", 5'b0, 5'b0, 5'b0, 5'b0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("post_rst_%0d", k), 5'b0, 5'b0, 5'b0, 5'b0);
        end
        tick();
        chk("post_rst_accept", 5'b11111, 5'b11111, 5'b0, 5'b11111);
        tick();
        chk("post_rst_after", 5'b11111, 5'b0, 5'b0, 5'b11111);

        // Release everything at once: five simultaneous release pulses.
        btn_raw = '0;
        for (int k = 0; k < 5; k++) tick();
        tick();
        chk("all_release", 5'b0, 5'b0, 5'b11111, 5'b11111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
